// File: rtl/vga_pixel_dma_ctrl.sv
// Frame-buffer read DMA feeding a show-ahead pixel FIFO, with double-buffer swap.
// Optional macro VGA_PIXEL_DMA_UNDERFLOW_CNT_EN adds a saturating underflow_count output.
module vga_pixel_dma_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 30,
    parameter int PIXELS     = 307200,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_STEP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              back_base_wr,
    input  logic [ADDR_W-1:0] back_base_data,
    input  logic              swap_req,
    output logic              swap_pending,
    output logic [ADDR_W-1:0] front_base,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,
    input  logic              pix_ready,
    input  logic              end_of_frame,
    output logic [DATA_W-1:0] pix_data,
`ifdef VGA_PIXEL_DMA_UNDERFLOW_CNT_EN
    output logic [15:0]       underflow_count,
`endif
    output logic              underflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int FW = PW + 3;
    localparam int CW = $clog2(PIXELS + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WAIT_EOF} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] back_base;
    logic [CW-1:0]     word_cnt;
    logic [FW-1:0]     fifo_cnt, outstanding, discard, inflight, out_nxt;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              empty, accept, last_read, late, do_swap;
    logic              ret_live, ret_drop, push, pop, starve;

    // Stale returns from an aborted frame are counted in discard, not outstanding.
    assign empty     = fifo_cnt == '0;
    assign inflight  = fifo_cnt + outstanding + discard;
    assign m_read    = state == FETCH && !end_of_frame &&
                       inflight < FW'(FIFO_DEPTH);
    assign accept    = m_read && !m_waitrequest;
    assign last_read = accept && word_cnt == CW'(PIXELS - 1);
    assign late      = end_of_frame && (state == FETCH || state == DRAIN);
    assign do_swap   = end_of_frame && swap_pending;
    assign ret_drop  = m_readdatavalid && discard != '0;
    assign ret_live  = m_readdatavalid && discard == '0 && outstanding != '0;
    assign push      = ret_live && !late;
    assign pop       = pix_ready && !empty && !late;
    assign starve    = pix_ready && empty;
    assign out_nxt   = outstanding + FW'(accept) - FW'(ret_live);
    assign pix_data  = empty ? '0 : mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (end_of_frame) state_nxt = FETCH;
            FETCH:    if (end_of_frame) state_nxt = FETCH;
                      else if (last_read) state_nxt = DRAIN;
            DRAIN:    if (end_of_frame) state_nxt = FETCH;
                      else if (out_nxt == '0) state_nxt = WAIT_EOF;
            WAIT_EOF: if (end_of_frame) state_nxt = FETCH;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            word_cnt     <= '0;
            m_address    <= '0;
            outstanding  <= '0;
            discard      <= '0;
            fifo_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            front_base   <= '0;
            back_base    <= '0;
            swap_pending <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (end_of_frame) begin
                word_cnt  <= '0;
                m_address <= do_swap ? back_base : front_base;
            end else if (accept) begin
                word_cnt  <= word_cnt + CW'(1);
                m_address <= m_address + ADDR_W'(ADDR_STEP);
            end
            if (late) begin
                outstanding <= '0;
                discard     <= discard - FW'(ret_drop) + outstanding - FW'(ret_live);
                fifo_cnt    <= '0;
                rd_ptr      <= wr_ptr;
            end else begin
                outstanding <= out_nxt;
                discard     <= discard - FW'(ret_drop);
                fifo_cnt    <= fifo_cnt + FW'(push) - FW'(pop);
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
            end
            // A request landing on the swap edge waits for the next frame.
            if (do_swap) begin
                front_base   <= back_base;
                back_base    <= back_base_wr ? back_base_data : front_base;
                swap_pending <= swap_req;
            end else begin
                if (back_base_wr) back_base <= back_base_data;
                if (swap_req) swap_pending <= 1'b1;
            end
            if (starve) underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= m_readdata;
    end

`ifdef VGA_PIXEL_DMA_UNDERFLOW_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) underflow_count <= '0;
        else if (starve && underflow_count != 16'hFFFF)
            underflow_count <= underflow_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_pixel_dma_ctrl.sv
// Scoreboard bench for vga_pixel_dma_ctrl: in-order Avalon memory model and pixel consumer.
module tb_vga_pixel_dma_ctrl;
    localparam int AW = 32;
    localparam int DW = 30;
    localparam int NPIX = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset, back_base_wr, swap_req, swap_pending;
    logic [AW-1:0] back_base_data, front_base, m_address;
    logic          m_read, m_waitrequest, m_readdatavalid;
    logic [DW-1:0] m_readdata, pix_data;
    logic          pix_ready, end_of_frame, underflow;
`ifdef VGA_PIXEL_DMA_UNDERFLOW_CNT_EN
    logic [15:0]   underflow_count;
`endif

    always #5 clk = ~clk;

    vga_pixel_dma_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .PIXELS(NPIX),
        .FIFO_DEPTH(DEPTH), .ADDR_STEP(4)
    ) dut (
        .clk(clk), .reset(reset),
        .back_base_wr(back_base_wr), .back_base_data(back_base_data),
        .swap_req(swap_req), .swap_pending(swap_pending),
        .front_base(front_base), .m_address(m_address), .m_read(m_read),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .pix_ready(pix_ready),
        .end_of_frame(end_of_frame), .pix_data(pix_data),
`ifdef VGA_PIXEL_DMA_UNDERFLOW_CNT_EN
        .underflow_count(underflow_count),
`endif
        .underflow(underflow)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
        bit            stale;
    } resp_t;

    resp_t         rq[$];
    logic [DW-1:0] exp_q[$];
    int            vectors = 0, miscompares = 0;
    int            cyc = 0, lat = 2, issued = NPIX, hold = 0;
    bit            stall_en = 0;
    logic [AW-1:0] exp_addr = '0, m_front = '0, m_back = '0;
    logic          m_pend = 0, m_uf = 0;
    logic [15:0]   ufc = '0;
    logic          d_rst = 0, d_eof = 0, d_rdy = 0, d_bwr = 0, d_sreq = 0;
    logic [AW-1:0] d_bdata = '0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(logic [AW-1:0] a);
        return a[DW-1:0] ^ 30'h2AA5_5A5A;
    endfunction

    function automatic int live_cnt();
        int n = 0;
        foreach (rq[i]) if (!rq[i].stale) n++;
        return n;
    endfunction

    task automatic tick();
        bit            late;
        resp_t         r;
        logic [AW-1:0] nf;
        @(negedge clk);
        cyc++;
        chk("front_base", front_base, m_front);
        chk("swap_pending", swap_pending, m_pend);
        chk("underflow", underflow, m_uf);
`ifdef VGA_PIXEL_DMA_UNDERFLOW_CNT_EN
        chk("underflow_count", underflow_count, ufc);
`endif
        late = d_eof && !d_rst && (issued < NPIX || live_cnt() > 0);
        if (d_rst || late) begin
            foreach (rq[i]) rq[i].stale = 1;
            exp_q.delete();
        end
        if (d_rst) begin
            m_front = '0; m_back = '0; m_pend = 0; m_uf = 0; ufc = '0;
            issued = NPIX;
        end else begin
            if (d_rdy) begin
                if (exp_q.size() > 0) chk("pix_data", pix_data, exp_q.pop_front());
                else begin
                    chk("pix_zero", pix_data, 0);
                    m_uf = 1;
                    if (ufc != 16'hFFFF) ufc++;
                end
            end
            if (d_eof && m_pend) begin
                nf = m_back;
                m_back = d_bwr ? d_bdata : m_front;
                m_front = nf;
                m_pend = d_sreq;
            end else begin
                if (d_bwr) m_back = d_bdata;
                if (d_sreq) m_pend = 1;
            end
            if (d_eof) begin
                issued = 0; hold = 0; exp_addr = m_front;
            end
        end
        m_readdatavalid = 0;
        m_readdata = '0;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            r = rq.pop_front();
            m_readdatavalid = 1;
            m_readdata = r.data;
            if (!r.stale) exp_q.push_back(r.data);
        end
        reset = d_rst; end_of_frame = d_eof; pix_ready = d_rdy;
        back_base_wr = d_bwr; back_base_data = d_bdata; swap_req = d_sreq;
        m_waitrequest = 0;
        #1;
        if (!d_rst) begin
            if (stall_en && m_read && issued == 1 && hold < 5) begin
                m_waitrequest = 1;
                hold++;
                chk("stall_addr", m_address, exp_addr);
            end
            #1;
            if (m_read && !m_waitrequest) begin
                chk("rd_addr", m_address, exp_addr);
                chk("rd_count", issued < NPIX, 1);
                rq.push_back('{data: mem_word(m_address), due: cyc + lat, stale: 0});
                issued++;
                exp_addr += 4;
                chk("inflight", (live_cnt() + exp_q.size()) <= DEPTH, 1);
            end
        end
        d_eof = 0; d_bwr = 0; d_sreq = 0;
    endtask

    task automatic run_frame(string tag);
        int n;
        for (n = 0; n < 300; n++) begin
            if (issued >= NPIX && live_cnt() == 0 && exp_q.size() == 0) break;
            d_rdy = exp_q.size() > 0 && (n % 3 != 1);
            tick();
        end
        d_rdy = 0;
        chk({tag, "_done"}, n < 300, 1);
        repeat (3) tick();
        chk({tag, "_idle"}, m_read, 0);
    endtask

    task automatic run_until_issued(int k);
        for (int n = 0; n < 50 && issued < k; n++) begin
            d_sreq = (issued == 1);
            tick();
        end
        chk("reach_issued", issued, k);
    endtask

    initial begin
        reset = 1; end_of_frame = 0; pix_ready = 0; back_base_wr = 0;
        back_base_data = '0; swap_req = 0; m_waitrequest = 0;
        m_readdatavalid = 0; m_readdata = '0;
        repeat (2) @(posedge clk);
        d_rst = 1; tick(); d_rst = 0; tick();
        chk("rst_mread", m_read, 0);
        chk("rst_maddr", m_address, 0);
        chk("rst_pix", pix_data, 0);

        d_rdy = 1; tick(); d_rdy = 0; tick();
        d_rst = 1; tick(); d_rst = 0; tick();

        d_bwr = 1; d_bdata = 32'h1000; d_sreq = 1; tick(); tick();
        lat = 2; stall_en = 1; d_eof = 1; tick();
        run_frame("f1");
        stall_en = 0;

        d_bwr = 1; d_bdata = 32'h2000; d_sreq = 1; tick();
        lat = 3; d_eof = 1; tick();
        run_frame("f2");

        d_sreq = 1; tick();
        lat = 1; d_eof = 1; d_sreq = 1; tick();
        run_frame("f3");

        d_eof = 1; d_bwr = 1; d_bdata = 32'h3000; tick();
        run_frame("f4");

        lat = 6; d_eof = 1; tick();
        run_until_issued(3);
        d_eof = 1; tick();
        lat = 2;
        run_frame("late");

        lat = 6; d_eof = 1; tick();
        run_until_issued(3);
        d_rst = 1; tick(); d_rst = 0;
        repeat (10) tick();
        chk("rst_flush", pix_data, 0);
        lat = 2; d_eof = 1; tick();
        run_frame("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
